// File: rtl/condition_evaluator_pkg.sv
// Shared control-unit definitions: condition codes, flag bit positions and
// the cond_sel field layout used by the evaluator and its decoder.
package condition_evaluator_pkg;

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
    CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
    CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
    CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
  } cond_code_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int SEL_IDX_W = 4;
  localparam int SEL_W     = SEL_IDX_W + 1;

  // cond_sel: ext=1 picks an external channel, otherwise idx is a cond_code_e
  typedef struct packed {
    logic                 ext;
    logic [SEL_IDX_W-1:0] idx;
  } cond_sel_t;

endpackage

// File: rtl/condition_evaluator_decode.sv
// Combinational 16-way architectural condition decode over {N,Z,C,V}.
module cond_decode
  import condition_evaluator_pkg::*;
(
  input  logic [3:0]  flags,
  input  cond_code_e  code,
  output logic        result
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    result = 1'b0;
    case (code)
      CC_EQ: result = z;
      CC_NE: result = ~z;
      CC_CS: result = c;
      CC_CC: result = ~c;
      CC_MI: result = n;
      CC_PL: result = ~n;
      CC_VS: result = v;
      CC_VC: result = ~v;
      CC_HI: result = c & ~z;
      CC_LS: result = ~c | z;
      CC_GE: result = (n == v);
      CC_LT: result = (n != v);
      CC_GT: result = ~z & (n == v);
      CC_LE: result = z | (n != v);
      CC_AL: result = 1'b1;
      CC_NV: result = 1'b0;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/condition_evaluator.sv
// Flag register plus single-cycle registered condition evaluation over
// architectural codes or external condition channels.
module condition_evaluator
  import condition_evaluator_pkg::*;
#(
  parameter int FORWARD = 1,
  parameter int EXT_N   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [3:0]                         flags_in,
  input  logic                               flags_we,
  input  logic                               eval_valid,
  input  logic [SEL_W-1:0]                   cond_sel,
  input  logic [((EXT_N > 0) ? EXT_N : 1)-1:0] ext_cond,
  input  logic                               flush,
  output logic                               cond_true,
  output logic                               cond_valid,
  output logic [3:0]                         flags_q
);

  cond_sel_t  sel;
  logic [3:0] eff_flags;
  logic       arch_res;
  logic [15:0] ext_pad;
  logic       res;

  assign sel = cond_sel_t'(cond_sel);

  // Same-cycle flag writes can bypass the register when forwarding is enabled
  assign eff_flags = ((FORWARD != 0) && flags_we) ? flags_in : flags_q;

  cond_decode u_dec (
    .flags  (eff_flags),
    .code   (cond_code_e'(sel.idx)),
    .result (arch_res)
  );

  // Unimplemented channels read as zero
  always_comb begin
    ext_pad = '0;
    for (int i = 0; i < EXT_N; i++) ext_pad[i] = ext_cond[i];
  end

  assign res = sel.ext ? ext_pad[sel.idx] : arch_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= '0;
      cond_true  <= 1'b0;
      cond_valid <= 1'b0;
    end else begin
      if (flags_we) flags_q <= flags_in;
      cond_valid <= eval_valid & ~flush;
      if (flush)           cond_true <= 1'b0;
      else if (eval_valid) cond_true <= res;
    end
  end

endmodule

// File: tb/tb_condition_evaluator.sv
// Randomized and directed bench: two evaluators (FORWARD=0 / FORWARD=1)
// driven in lockstep and compared against a behavioural model.
module tb_condition_evaluator;

  localparam int EXT_N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, flags_we, eval_valid, flush;
  logic [3:0]       flags_in;
  logic [4:0]       cond_sel;
  logic [EXT_N-1:0] ext_cond;
  logic [1:0]       ct, cv;
  logic [1:0][3:0]  fq;

  condition_evaluator #(.FORWARD(0), .EXT_N(EXT_N)) dut_nf (
    .clk(clk), .reset(reset), .flags_in(flags_in), .flags_we(flags_we),
    .eval_valid(eval_valid), .cond_sel(cond_sel), .ext_cond(ext_cond),
    .flush(flush), .cond_true(ct[0]), .cond_valid(cv[0]), .flags_q(fq[0]));

  condition_evaluator #(.FORWARD(1), .EXT_N(EXT_N)) dut_fw (
    .clk(clk), .reset(reset), .flags_in(flags_in), .flags_we(flags_we),
    .eval_valid(eval_valid), .cond_sel(cond_sel), .ext_cond(ext_cond),
    .flush(flush), .cond_true(ct[1]), .cond_valid(cv[1]), .flags_q(fq[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Codes come in complementary pairs: odd code = negation of the even one.
  function automatic logic arch_cond(input logic [3:0] f, input logic [3:0] code);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  logic [3:0] m_flags [2];
  logic       m_true  [2];
  logic       m_valid [2];

  // Advance the model by one clock, clock the DUTs, then compare.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] ef;
      logic       r;
      ef = (k == 1 && flags_we) ? flags_in : m_flags[k];
      if (cond_sel[4]) r = (int'(cond_sel[3:0]) < EXT_N) ? ext_cond[cond_sel[3:0]] : 1'b0;
      else             r = arch_cond(ef, cond_sel[3:0]);
      if (reset) begin
        m_flags[k] = 4'h0; m_true[k] = 1'b0; m_valid[k] = 1'b0;
      end else begin
        if (flags_we) m_flags[k] = flags_in;
        if (flush) begin
          m_valid[k] = 1'b0; m_true[k] = 1'b0;
        end else if (eval_valid) begin
          m_valid[k] = 1'b1; m_true[k] = r;
        end else begin
          m_valid[k] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("flags_q[fw%0d]", k),    32'(fq[k]), 32'(m_flags[k]));
      chk($sformatf("cond_valid[fw%0d]", k), 32'(cv[k]), 32'(m_valid[k]));
      chk($sformatf("cond_true[fw%0d]", k),  32'(ct[k]), 32'(m_true[k]));
    end
  endtask

  task automatic cyc(input logic rst, input logic we, input logic [3:0] fin,
                     input logic ev, input logic [4:0] sel, input logic fl);
    reset = rst; flags_we = we; flags_in = fin;
    eval_valid = ev; cond_sel = sel; flush = fl;
    step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_flags[k] = 4'h0; m_true[k] = 1'b0; m_valid[k] = 1'b0;
    end
    ext_cond = '0;
    reset = 1'b1; flags_we = 1'b0; flags_in = 4'h0;
    eval_valid = 1'b0; cond_sel = 5'h0; flush = 1'b0;
    @(negedge clk);

    // Reset, with a request and flag write presented during reset
    cyc(1, 1, 4'hF, 1, 5'h0E, 0);
    cyc(1, 0, 4'h0, 0, 5'h00, 0);
    chk("rst_flags", 32'(fq[1]), 32'h0);
    chk("rst_valid", 32'(cv[1]), 32'h0);
    cyc(0, 0, 4'h0, 0, 5'h00, 0);
    chk("rst_no_late_valid", 32'(cv[1]), 32'h0);

    // Load Z then evaluate EQ
    cyc(0, 1, 4'b0100, 0, 5'h00, 0);
    chk("load_flags", 32'(fq[1]), 32'h4);
    cyc(0, 0, 4'h0, 1, 5'h00, 0);
    chk("eq_true", 32'(ct[1]), 32'h1);
    chk("eq_valid", 32'(cv[1]), 32'h1);

    // All codes against all stored flag values
    for (int f = 0; f < 16; f++) begin
      cyc(0, 1, 4'(f), 0, 5'h00, 0);
      for (int c = 0; c < 16; c++) cyc(0, 0, 4'h0, 1, {1'b0, 4'(c)}, 0);
    end

    // Forwarding versus stored flags in the same cycle
    cyc(1, 0, 4'h0, 0, 5'h00, 0);
    cyc(0, 1, 4'b0100, 1, 5'h00, 0);
    chk("fwd1_eq", 32'(ct[1]), 32'h1);
    chk("fwd0_eq", 32'(ct[0]), 32'h0);

    // External channels, including an unimplemented index
    ext_cond = 4'b1010;
    cyc(0, 0, 4'h0, 1, 5'h11, 0);
    chk("ext1", 32'(ct[1]), 32'h1);
    cyc(0, 0, 4'h0, 1, 5'h10, 0);
    chk("ext0", 32'(ct[1]), 32'h0);
    cyc(0, 0, 4'h0, 1, 5'h13, 0);
    cyc(0, 0, 4'h0, 1, 5'h15, 0);
    chk("ext5", 32'(ct[1]), 32'h0);

    // Flush kills the result but not the flag write
    cyc(0, 0, 4'h0, 1, 5'h0E, 0);
    cyc(0, 1, 4'hF, 1, 5'h0E, 1);
    chk("flush_valid", 32'(cv[1]), 32'h0);
    chk("flush_true", 32'(ct[1]), 32'h0);
    chk("flush_flags", 32'(fq[0]), 32'hF);

    // Eval then reset on the following edge
    cyc(0, 0, 4'h0, 1, 5'h0E, 0);
    chk("pre_rst_valid", 32'(cv[1]), 32'h1);
    cyc(1, 1, 4'h7, 1, 5'h0E, 1);
    chk("post_rst_valid", 32'(cv[1]), 32'h0);
    chk("post_rst_true", 32'(ct[1]), 32'h0);
    chk("post_rst_flags", 32'(fq[1]), 32'h0);

    // Random traffic, including idle cycles where cond_true must hold
    for (int i = 0; i < 3000; i++) begin
      ext_cond = 4'($urandom);
      cyc($urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom),
          $urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/condition_evaluator.md
CONDITION_EVALUATOR -- requirements
Module: condition_evaluator

Interface
REQ-001 Parameter FORWARD, default 1, SHALL select the flag source when a flag write and an evaluation occur in the same cycle (1 = flags_in, 0 = stored flags).
REQ-002 Parameter EXT_N, default 4, range 0..16, SHALL set the number of external condition channels.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port flags_in, input, 4 bits: candidate flags {N,Z,C,V}, bit 3 = N.
REQ-006 Port flags_we, input, 1 bit: load flags_in into the flag register.
REQ-007 Port eval_valid, input, 1 bit: an evaluation request is present this cycle.
REQ-008 Port cond_sel, input, 5 bits: bit 4 = 0 selects an architectural code in bits 3:0; bit 4 = 1 selects ext_cond[bits 3:0].
REQ-009 Port ext_cond, input, max(EXT_N,1) bits: external condition channels, sampled with eval_valid.
REQ-010 Port flush, input, 1 bit: kills the in-flight result.
REQ-011 Port cond_true, output, 1 bit: registered evaluation result.
REQ-012 Port cond_valid, output, 1 bit: cond_true is meaningful this cycle.
REQ-013 Port flags_q, output, 4 bits: current flag register contents.

Function
REQ-014 The flag register SHALL load flags_in on the clock edge where flags_we=1 and reset=0; otherwise it SHALL hold.
REQ-015 Effective flags for an evaluation SHALL be flags_in when FORWARD=1 and flags_we=1 in the same cycle; otherwise they SHALL be flags_q.
REQ-016 Architectural codes SHALL decode as: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
REQ-017 External select with index < EXT_N SHALL yield ext_cond[index]; index >= EXT_N (including any index when EXT_N=0) SHALL yield 0.
REQ-018 Latency SHALL be exactly one cycle: eval_valid=1 at edge k produces cond_valid=1 and the result on cond_true after edge k, held for one cycle only.
REQ-019 With eval_valid=0 at an edge, cond_valid SHALL become 0 and cond_true SHALL hold its previous value.
REQ-020 Back-to-back requests SHALL be accepted every cycle with no bubbles; there SHALL be no backpressure.
REQ-021 flush=1 at an edge SHALL force cond_valid=0 and cond_true=0, overriding any eval_valid in the same cycle.
REQ-022 flush SHALL NOT affect the flag register; a flags_we in the same cycle SHALL still load.
REQ-023 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-024 reset=1 at an edge SHALL set flags_q=4'b0000, cond_true=0 and cond_valid=0.
REQ-025 reset SHALL take priority over flags_we, eval_valid and flush.
REQ-026 A request presented during reset SHALL be discarded and produce no cond_valid afterwards.

Structure
REQ-027 The condition-code constants (EQ..NV), the flag bit positions (N=3, Z=2, C=1, V=0) and the cond_sel field layout SHALL reside in a shared control-unit package reused by the decoder.
REQ-028 The 16-way architectural decode SHALL be a combinational sub-module cond_decode (inputs: flags, code; output: 1-bit result); all registers SHALL live in condition_evaluator.

Verification
REQ-029 Reset then flags_we=1, flags_in=4'b0100, then eval cond_sel=5'h00 -> flags_q=4'b0100; one cycle later cond_true=1, cond_valid=1.
REQ-030 Sweep all 16 codes against all 16 stored flag values -> cond_true matches the REQ-016 table for all 256 cases, each with one-cycle latency.
REQ-031 With FORWARD=1 and flags_q=0, apply flags_we=1, flags_in=4'b0100 and eval EQ in the same cycle -> cond_true=1; repeat with FORWARD=0 -> cond_true=0.
REQ-032 With EXT_N=4 and ext_cond=4'b1010: cond_sel=5'h11 -> 1, 5'h10 -> 0, 5'h15 -> 0.
REQ-033 Apply eval AL with flush=1 in the same cycle -> cond_valid=0 and cond_true=0; flush with flags_we=1, flags_in=4'hF -> flags_q=4'hF.
REQ-034 Apply eval AL at cycle k and reset=1 at cycle k+1 -> cond_valid=1 after edge k, and cond_valid=0, cond_true=0, flags_q=0 after edge k+1.
